sx_writeback_stage: RTL
=======================

# sx_writeback_stage

Writeback/retire stage that consumes the single-cycle execute pipeline output (sx_*) and the memory pipeline output (dd_*). It arbitrates both onto the single register-file write port and the single rollback port, and enforces a per-thread squash window after each rollback. Its wb_rollback_en/wb_rollback_thread_idx outputs are the rollback signals fed back to the execute and earlier stages.

## Interface
- NUM_THREADS, 4, hardware threads; thread index width T = $clog2(NUM_THREADS)
- VECTOR_LANES, 16, lanes per vector, 32 bits each
- SQUASH_CYCLES, 2, cycles after a rollback during which that thread's results are discarded (1..7)

Clock/reset: one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sx_instruction_valid / dd_instruction_valid  in  1  source has an instruction this cycle
- sx_thread_idx / dd_thread_idx  in  T  issuing thread
- sx_has_dest / dd_has_dest  in  1  instruction writes a register
- sx_dest_is_vector / dd_dest_is_vector  in  1  destination is a vector register
- sx_dest_reg / dd_dest_reg  in  5  destination register
- sx_result / dd_result  in  32*VECTOR_LANES  result, lane 0 at LSBs
- sx_mask_value / dd_mask_value  in  VECTOR_LANES  lane write enables
- sx_rollback_en / dd_rollback_en  in  1  redirect request
- sx_rollback_pc / dd_rollback_pc  in  32  redirect target
- sx_is_eret  in  1  instruction is eret
- wb_writeback_en  out  1  register-file write strobe
- wb_writeback_thread_idx  out  T  write thread
- wb_writeback_is_vector  out  1  vector write
- wb_writeback_reg  out  5  write register
- wb_writeback_value  out  32*VECTOR_LANES  write data
- wb_writeback_mask  out  VECTOR_LANES  lane enables; all ones for scalar writes
- wb_rollback_en  out  1  one-cycle rollback pulse
- wb_rollback_thread_idx  out  T  rolled-back thread
- wb_rollback_pc  out  32  new PC
- wb_eret  out  1  retired eret, asserted with its rollback
- wb_retire  out  1  one instruction retired this cycle
- wb_overflow  out  1  sticky skid-buffer overflow error

## Operation
- One candidate is selected per cycle, in priority order:
  1. dd, if dd is valid;
  2. otherwise the skid entry, if the skid buffer is full;
  3. otherwise sx.
- Collision: when sx and dd are both valid in a cycle, dd wins. The sx instruction, with all its fields, is captured in a one-entry skid buffer.
- Overflow: if the skid buffer is already full, is not drained this cycle, and a new sx instruction must be captured, the new sx is dropped and wb_overflow sets. wb_overflow clears only on reset.
- Squash check: a candidate is squashed when squash_cnt[thread] != 0, or when its thread equals the thread being rolled back in the same cycle. This covers a skid entry or sx from the same thread as a dd rollback; such an entry is dropped.
- A squashed candidate produces no write, no rollback and no retire.
- A surviving candidate:
  - wb_writeback_en = has_dest. Mask = mask_value if is_vector, else all ones.
  - wb_rollback_en = rollback_en, with its PC and thread.
  - wb_eret = is_eret && rollback_en.
  - wb_retire = 1.
- Squash counters: when a rollback issues for thread t, squash_cnt[t] loads SQUASH_CYCLES. Otherwise every nonzero counter decrements once per cycle. A counter saturates at 0 and never wraps.
- Deferral across threads: an sx candidate from a different thread than a same-cycle dd rollback is deferred via the skid buffer, not squashed, so a rollback is never lost.

## Timing
- All wb_* outputs are registered: an input accepted in cycle N appears at cycle N+1.
- A skid-buffered sx retires no earlier than N+2.
- wb_rollback_en, wb_retire and wb_eret are single-cycle pulses per accepted instruction.
- The skid buffer drains in the first cycle in which dd is not valid.
- At most one write and one rollback are issued per cycle.
- Reset values: all outputs 0, including wb_writeback_value, wb_rollback_pc and wb_overflow. The skid buffer is empty and all squash_cnt are 0.
- Reset asserted mid-operation discards the skid entry and all squash state immediately; nothing is retired after reset_n deasserts until a new valid input arrives.

## Test plan
- **Single sx.** sx valid, thread 1, scalar, r5, result lane0 = 0x1234 → next cycle:
  - wb_writeback_en = 1, reg 5, thread 1, mask = 0xFFFF, value lane0 = 0x1234;
  - wb_retire = 1.
- **Collision.** sx (thread 0, r3) and dd (thread 2, r7) valid in cycle N →
  - N+1: dd write to r7;
  - N+2: sx write to r3;
  - wb_overflow stays 0.
- **Rollback squash.** dd rollback for thread 2 to PC 0x1000, SQUASH_CYCLES = 2; sx from thread 2 in cycles N+1 and N+2; sx from thread 2 in N+3 →
  - wb_rollback_en pulses once with PC 0x1000;
  - the N+1 and N+2 instructions are dropped;
  - the N+3 instruction retires.
- **Same-cycle rollback, same thread.** dd rollback (thread 3) and sx (thread 3, writes r1) in the same cycle → sx never written; exactly one rollback pulse.
- **Overflow.** dd valid for 2 consecutive cycles with sx valid in both → the second sx is dropped and wb_overflow latches 1 until reset.
- **Async reset mid-operation.** Skid buffer full and squash_cnt = 2, then reset_n low for 1 cycle →
  - all outputs 0 asynchronously;
  - after release, the next sx from the previously squashed thread retires normally.

Source files
------------

// File: rtl/sx_writeback_stage_if.sv
// Bundle of execute-pipe, memory-pipe and writeback signals for sx_writeback_stage.
// The master side drives the sx_*/dd_* pipeline outputs and observes wb_*;
// the slave side (the writeback stage) consumes sx_*/dd_* and produces wb_*.
interface sx_writeback_stage_if #(
  parameter int NUM_THREADS  = 4,
  parameter int VECTOR_LANES = 16
);
  localparam int T = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int W = 32 * VECTOR_LANES;

  // Single-cycle execute pipeline output
  logic                    sx_instruction_valid;
  logic [T-1:0]            sx_thread_idx;
  logic                    sx_has_dest;
  logic                    sx_dest_is_vector;
  logic [4:0]              sx_dest_reg;
  logic [W-1:0]            sx_result;
  logic [VECTOR_LANES-1:0] sx_mask_value;
  logic                    sx_rollback_en;
  logic [31:0]             sx_rollback_pc;
  logic                    sx_is_eret;

  // Memory pipeline output
  logic                    dd_instruction_valid;
  logic [T-1:0]            dd_thread_idx;
  logic                    dd_has_dest;
  logic                    dd_dest_is_vector;
  logic [4:0]              dd_dest_reg;
  logic [W-1:0]            dd_result;
  logic [VECTOR_LANES-1:0] dd_mask_value;
  logic                    dd_rollback_en;
  logic [31:0]             dd_rollback_pc;

  // Writeback / retire outputs
  logic                    wb_writeback_en;
  logic [T-1:0]            wb_writeback_thread_idx;
  logic                    wb_writeback_is_vector;
  logic [4:0]              wb_writeback_reg;
  logic [W-1:0]            wb_writeback_value;
  logic [VECTOR_LANES-1:0] wb_writeback_mask;
  logic                    wb_rollback_en;
  logic [T-1:0]            wb_rollback_thread_idx;
  logic [31:0]             wb_rollback_pc;
  logic                    wb_eret;
  logic                    wb_retire;
  logic                    wb_overflow;

  modport master (
    output sx_instruction_valid, sx_thread_idx, sx_has_dest, sx_dest_is_vector,
           sx_dest_reg, sx_result, sx_mask_value, sx_rollback_en, sx_rollback_pc,
           sx_is_eret,
    output dd_instruction_valid, dd_thread_idx, dd_has_dest, dd_dest_is_vector,
           dd_dest_reg, dd_result, dd_mask_value, dd_rollback_en, dd_rollback_pc,
    input  wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
           wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
           wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc,
           wb_eret, wb_retire, wb_overflow
  );

  modport slave (
    input  sx_instruction_valid, sx_thread_idx, sx_has_dest, sx_dest_is_vector,
           sx_dest_reg, sx_result, sx_mask_value, sx_rollback_en, sx_rollback_pc,
           sx_is_eret,
    input  dd_instruction_valid, dd_thread_idx, dd_has_dest, dd_dest_is_vector,
           dd_dest_reg, dd_result, dd_mask_value, dd_rollback_en, dd_rollback_pc,
    output wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
           wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
           wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pc,
           wb_eret, wb_retire, wb_overflow
  );
endinterface

// File: rtl/sx_writeback_stage.sv
// Writeback/retire stage: arbitrates the execute (sx) and memory (dd) pipes onto
// one register-file write port and one rollback port. A one-entry skid buffer
// holds an sx instruction that lost arbitration to dd, and per-thread squash
// counters discard a thread's results for a few cycles after its rollback.
module sx_writeback_stage #(
  parameter int NUM_THREADS   = 4,
  parameter int VECTOR_LANES  = 16,
  parameter int SQUASH_CYCLES = 2
) (
  input logic clk,
  input logic reset_n,
  sx_writeback_stage_if.slave bus
);
  localparam int T = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int W = 32 * VECTOR_LANES;

  typedef struct packed {
    logic [T-1:0]            thread_idx;
    logic                    has_dest;
    logic                    dest_is_vector;
    logic [4:0]              dest_reg;
    logic [W-1:0]            result;
    logic [VECTOR_LANES-1:0] mask_value;
    logic                    rollback_en;
    logic [31:0]             rollback_pc;
    logic                    is_eret;
  } entry_t;

  entry_t     sx_entry;
  entry_t     dd_entry;
  entry_t     skid;
  entry_t     cand;
  logic       skid_valid;
  logic [2:0] squash_cnt [NUM_THREADS];

  logic cand_valid;
  logic cand_ok;
  logic rollback_issue;
  logic skid_drained;
  logic skid_dropped;
  logic skid_free;
  logic sx_needs_skid;
  logic sx_same_rb_thread;
  logic skid_load;
  logic overflow_event;

  // Gather each pipe's fields into a common entry format; dd never carries eret
  always_comb begin
    sx_entry.thread_idx     = bus.sx_thread_idx;
    sx_entry.has_dest       = bus.sx_has_dest;
    sx_entry.dest_is_vector = bus.sx_dest_is_vector;
    sx_entry.dest_reg       = bus.sx_dest_reg;
    sx_entry.result         = bus.sx_result;
    sx_entry.mask_value     = bus.sx_mask_value;
    sx_entry.rollback_en    = bus.sx_rollback_en;
    sx_entry.rollback_pc    = bus.sx_rollback_pc;
    sx_entry.is_eret        = bus.sx_is_eret;
    dd_entry.thread_idx     = bus.dd_thread_idx;
    dd_entry.has_dest       = bus.dd_has_dest;
    dd_entry.dest_is_vector = bus.dd_dest_is_vector;
    dd_entry.dest_reg       = bus.dd_dest_reg;
    dd_entry.result         = bus.dd_result;
    dd_entry.mask_value     = bus.dd_mask_value;
    dd_entry.rollback_en    = bus.dd_rollback_en;
    dd_entry.rollback_pc    = bus.dd_rollback_pc;
    dd_entry.is_eret        = 1'b0;
  end

  // Pick this cycle's candidate (dd, then skid, then sx), apply squash, and decide skid fate
  always_comb begin
    cand       = sx_entry;
    cand_valid = 1'b0;
    if (bus.dd_instruction_valid) begin
      cand       = dd_entry;
      cand_valid = 1'b1;
    end else if (skid_valid) begin
      cand       = skid;
      cand_valid = 1'b1;
    end else if (bus.sx_instruction_valid) begin
      cand       = sx_entry;
      cand_valid = 1'b1;
    end

    cand_ok        = cand_valid && (squash_cnt[cand.thread_idx] == 3'd0);
    rollback_issue = cand_ok && cand.rollback_en;

    // The skid entry leaves either by being the candidate or by belonging to
    // the thread that dd is rolling back right now.
    skid_drained = skid_valid && !bus.dd_instruction_valid;
    skid_dropped = skid_valid && bus.dd_instruction_valid && rollback_issue &&
                   (skid.thread_idx == cand.thread_idx);
    skid_free    = !skid_valid || skid_drained || skid_dropped;

    // An sx that is not the candidate must wait in the skid buffer unless its
    // thread is being rolled back this cycle, in which case it is discarded.
    sx_needs_skid     = bus.sx_instruction_valid &&
                        (bus.dd_instruction_valid || skid_valid);
    sx_same_rb_thread = rollback_issue && (bus.sx_thread_idx == cand.thread_idx);
    skid_load         = sx_needs_skid && !sx_same_rb_thread && skid_free;
    overflow_event    = sx_needs_skid && !sx_same_rb_thread && !skid_free;
  end

  // Skid buffer occupancy and contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid <= 1'b0;
      skid       <= '0;
    end else begin
      skid_valid <= skid_load || !skid_free;
      if (skid_load) begin
        skid <= sx_entry;
      end
    end
  end

  // Per-thread squash windows: reload on rollback, otherwise count down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        squash_cnt[t] <= 3'd0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (rollback_issue && (cand.thread_idx == T'(t))) begin
          squash_cnt[t] <= 3'(SQUASH_CYCLES);
        end else if (squash_cnt[t] != 3'd0) begin
          squash_cnt[t] <= squash_cnt[t] - 3'd1;
        end
      end
    end
  end

  // Registered retire, write and rollback outputs for the surviving candidate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wb_writeback_en         <= 1'b0;
      bus.wb_writeback_thread_idx <= '0;
      bus.wb_writeback_is_vector  <= 1'b0;
      bus.wb_writeback_reg        <= '0;
      bus.wb_writeback_value      <= '0;
      bus.wb_writeback_mask       <= '0;
      bus.wb_rollback_en          <= 1'b0;
      bus.wb_rollback_thread_idx  <= '0;
      bus.wb_rollback_pc          <= '0;
      bus.wb_eret                 <= 1'b0;
      bus.wb_retire               <= 1'b0;
    end else begin
      bus.wb_writeback_en <= cand_ok && cand.has_dest;
      bus.wb_rollback_en  <= rollback_issue;
      bus.wb_eret         <= rollback_issue && cand.is_eret;
      bus.wb_retire       <= cand_ok;
      if (cand_ok) begin
        bus.wb_writeback_thread_idx <= cand.thread_idx;
        bus.wb_writeback_is_vector  <= cand.dest_is_vector;
        bus.wb_writeback_reg        <= cand.dest_reg;
        bus.wb_writeback_value      <= cand.result;
        bus.wb_writeback_mask       <= cand.dest_is_vector ? cand.mask_value : '1;
        bus.wb_rollback_thread_idx  <= cand.thread_idx;
        bus.wb_rollback_pc          <= cand.rollback_pc;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wb_overflow <= 1'b0;
    end else if (overflow_event) begin
      bus.wb_overflow <= 1'b1;
    end
  end
endmodule
